// File: rtl/fp64_round_pipe_pkg.sv
// Shared binary64 types and constants for the rounding/packing datapath.
package fp64_round_pipe_pkg;

    localparam int FP_EMSB = 10;
    localparam int FP_FMSB = 51;

    typedef struct packed {
        logic               sign;
        logic [FP_EMSB:0]   exp;
        logic [FP_FMSB+4:0] sig;
    } FP64N;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } fp_rm_t;

    localparam logic [63:0] FP64_QNAN   = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] FP64_MAXFIN = 64'h7FEF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/fp_round_incr.sv
// Round-increment decision from mode, sign and the L/G/R/S bits.
module fp_round_incr
    import fp64_round_pipe_pkg::*;
(
    input  logic [2:0] rm,
    input  logic       sign,
    input  logic       l,
    input  logic       g,
    input  logic       r,
    input  logic       s,
    output logic       inc
);

    logic inexact;

    assign inexact = g | r | s;

    // Undefined modes 5-7 fall through to round-to-nearest-even.
    always_comb begin
        inc = g & (l | r | s);
        case (rm)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign & inexact;
            RM_RUP:  inc = ~sign & inexact;
            RM_RMM:  inc = g;
            default: inc = g & (l | r | s);
        endcase
    end

endmodule

// File: rtl/fp64_round_pipe.sv
// Three-stage binary64 round-and-pack unit with a stallable valid/ready pipe.
module fp64_round_pipe
    import fp64_round_pipe_pkg::*;
#(
    parameter int EMSB  = 10,
    parameter int FMSB  = 51,
    parameter int FPWID = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic             i_sign,
    input  logic [EMSB:0]    i_exp,
    input  logic [FMSB+4:0]  i_sig,
    input  logic             i_under,
    input  logic [2:0]       i_rm,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [FPWID-1:0] o,
    output logic             o_inexact,
    output logic             o_overflow,
    output logic             o_underflow
);

    localparam int SW = EMSB + FMSB + 2;

    logic en;
    logic v1, v2, v3;

    assign en      = o_ready | ~o_valid;
    assign i_ready = en;
    assign o_valid = v3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else if (en) begin
            v1 <= i_valid;
            v2 <= v1;
        end
    end

    logic            s1_sign, s1_under, s1_special, s1_zero;
    logic [EMSB:0]   s1_exp;
    logic [FMSB+3:0] s1_sig;
    logic [2:0]      s1_rm;

    always_ff @(posedge clk) begin
        if (en) begin
            s1_sign    <= i_sign;
            s1_exp     <= i_exp;
            s1_sig     <= i_sig[FMSB+3:0];
            s1_under   <= i_under;
            s1_rm      <= i_rm;
            s1_special <= &i_exp;
            s1_zero    <= (i_exp == '0) && (i_sig == '0);
        end
    end

    logic          inc, s1_inexact;
    logic [SW-1:0] sum;

    fp_round_incr u_incr (
        .rm   (s1_rm),
        .sign (s1_sign),
        .l    (s1_sig[3]),
        .g    (s1_sig[2]),
        .r    (s1_sig[1]),
        .s    (s1_sig[0]),
        .inc  (inc)
    );

    assign s1_inexact = |s1_sig[2:0];
    // Fraction carry ripples into the exponent field.
    assign sum = {s1_exp, s1_sig[FMSB+3:3]} + {{(SW-1){1'b0}}, inc};

    logic          s2_sign, s2_special, s2_zero, s2_inexact, s2_tiny;
    logic [SW-1:0] s2_sum;
    logic [FMSB:0] s2_frac;
    logic [2:0]    s2_rm;

    always_ff @(posedge clk) begin
        if (en) begin
            s2_sign    <= s1_sign;
            s2_special <= s1_special;
            s2_zero    <= s1_zero;
            s2_inexact <= s1_inexact;
            s2_tiny    <= s1_inexact & (s1_under | (s1_exp == '0));
            s2_sum     <= sum;
            s2_frac    <= s1_sig[FMSB+3:3];
            s2_rm      <= s1_rm;
        end
    end

    logic [FPWID-1:0] pk, inf_v, max_v, ovf_v;
    logic             ix, ov, uf;

    assign inf_v = {s2_sign, {(EMSB+1){1'b1}}, {(FMSB+1){1'b0}}};
    assign max_v = {s2_sign, {EMSB{1'b1}}, 1'b0, {(FMSB+1){1'b1}}};

    always_comb begin
        case (s2_rm)
            RM_RTZ:  ovf_v = max_v;
            RM_RDN:  ovf_v = s2_sign ? inf_v : max_v;
            RM_RUP:  ovf_v = s2_sign ? max_v : inf_v;
            default: ovf_v = inf_v;
        endcase
    end

    always_comb begin
        pk = {s2_sign, s2_sum};
        ix = s2_inexact;
        ov = 1'b0;
        uf = s2_tiny;
        if (s2_special) begin
            pk = {s2_sign, {(EMSB+1){1'b1}}, s2_frac};
            ix = 1'b0;
            uf = 1'b0;
        end else if (s2_zero) begin
            pk = {s2_sign, {(FPWID-1){1'b0}}};
            ix = 1'b0;
            uf = 1'b0;
        end else if (&s2_sum[SW-1:FMSB+1]) begin
            pk = ovf_v;
            ix = 1'b1;
            ov = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v3          <= 1'b0;
            o           <= '0;
            o_inexact   <= 1'b0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else if (en) begin
            v3          <= v2;
            o           <= pk;
            o_inexact   <= ix;
            o_overflow  <= ov;
            o_underflow <= uf;
        end
    end

endmodule

// File: tb/tb_fp64_round_pipe.sv
// Directed scoreboard bench for the binary64 round-and-pack pipeline.
module tb_fp64_round_pipe;
    import fp64_round_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_ready;
    logic        i_sign = 1'b0;
    logic [10:0] i_exp = '0;
    logic [55:0] i_sig = '0;
    logic        i_under = 1'b0;
    logic [2:0]  i_rm = '0;
    logic        o_valid;
    logic        o_ready = 1'b1;
    logic [63:0] o;
    logic        o_inexact, o_overflow, o_underflow;

    logic [66:0] sb[$];
    int          n_assert = 0;
    int          n_fail = 0;
    bit          pat_en = 1'b0;
    int          pat_i = 0;
    bit          mon_stall = 1'b0;
    logic [66:0] held;
    logic [66:0] obs;

    fp64_round_pipe dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_valid     (i_valid),
        .i_ready     (i_ready),
        .i_sign      (i_sign),
        .i_exp       (i_exp),
        .i_sig       (i_sig),
        .i_under     (i_under),
        .i_rm        (i_rm),
        .o_valid     (o_valid),
        .o_ready     (o_ready),
        .o           (o),
        .o_inexact   (o_inexact),
        .o_overflow  (o_overflow),
        .o_underflow (o_underflow)
    );

    always #5 clk = ~clk;

    assign obs = {o, o_inexact, o_overflow, o_underflow};

    task automatic chk(input string tag, input logic [67:0] got,
                       input logic [67:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Downstream ready: 1,0,0 repeating while the pattern is enabled.
    always @(negedge clk) begin
        o_ready = pat_en ? ((pat_i % 3) == 0) : 1'b1;
        if (pat_en) pat_i++;
    end

    always begin
        @(negedge clk);
        #2;
        if (rst_n) begin
            if (mon_stall)
                chk("stall_hold", {o_valid, obs}, {1'b1, held});
            if (o_valid && o_ready) begin
                if (sb.size() == 0) begin
                    n_assert++;
                    assert (sb.size() != 0) else begin
                        n_fail++;
                        $error("FAIL unexpected_out observed=%h expected=none", obs);
                    end
                end else begin
                    chk("result", {1'b1, obs}, {1'b1, sb.pop_front()});
                end
            end
            mon_stall = o_valid && !o_ready;
            held = obs;
        end else begin
            mon_stall = 1'b0;
        end
    end

    task automatic send(input logic sg, input logic [10:0] e,
                        input logic [55:0] sig, input logic un,
                        input logic [2:0] rm, input logic [66:0] ex);
        int t = 0;
        @(negedge clk);
        i_valid = 1'b1;
        i_sign  = sg;
        i_exp   = e;
        i_sig   = sig;
        i_under = un;
        i_rm    = rm;
        #1;
        while (!i_ready && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!i_ready) begin
            n_assert++;
            assert (i_ready === 1'b1) else begin
                n_fail++;
                $error("FAIL send_timeout observed=%b expected=1", i_ready);
            end
        end else begin
            @(posedge clk);
            sb.push_back(ex);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL drain observed=%0d pending expected=0", sb.size());
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {o_valid, obs}, 68'd0);
        chk("reset_ready", {67'd0, i_ready}, 68'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", {67'd0, i_ready}, 68'd1);

        send(0, 11'h3FF, 56'h80_0000_0000_0004, 0, RM_RNE, {64'h3FF0_0000_0000_0000, 3'b100});
        send(0, 11'h3FF, 56'h80_0000_0000_000C, 0, RM_RNE, {64'h3FF0_0000_0000_0002, 3'b100});
        send(0, 11'h3FF, 56'h80_0000_0000_000C, 0, 3'd5,   {64'h3FF0_0000_0000_0002, 3'b100});
        send(0, 11'h3FF, 56'h80_0000_0000_0004, 0, RM_RMM, {64'h3FF0_0000_0000_0001, 3'b100});
        send(0, 11'h3FF, 56'hFF_FFFF_FFFF_FFFC, 0, RM_RNE, {64'h4000_0000_0000_0000, 3'b100});
        send(0, 11'h7FE, 56'hFF_FFFF_FFFF_FFFC, 0, RM_RNE, {64'h7FF0_0000_0000_0000, 3'b110});
        send(0, 11'h7FE, 56'hFF_FFFF_FFFF_FFFC, 0, RM_RTZ, {64'h7FEF_FFFF_FFFF_FFFF, 3'b100});
        send(1, 11'h7FE, 56'hFF_FFFF_FFFF_FFFC, 0, RM_RUP, {64'hFFEF_FFFF_FFFF_FFFF, 3'b100});
        send(1, 11'h7FE, 56'hFF_FFFF_FFFF_FFFC, 0, RM_RDN, {64'hFFF0_0000_0000_0000, 3'b110});
        send(0, 11'h7FE, 56'hFF_FFFF_FFFF_FFFC, 0, RM_RUP, {64'h7FF0_0000_0000_0000, 3'b110});
        send(0, 11'h000, 56'h7F_FFFF_FFFF_FFFC, 1, RM_RNE, {64'h0010_0000_0000_0000, 3'b101});
        send(0, 11'h7FF, 56'hC0_0000_0000_0004, 0, RM_RNE, {FP64_QNAN, 3'b000});
        send(1, 11'h000, 56'h00_0000_0000_0000, 0, RM_RUP, {64'h8000_0000_0000_0000, 3'b000});
        send(1, 11'h3FF, 56'h80_0000_0000_0001, 0, RM_RDN, {64'hBFF0_0000_0000_0001, 3'b100});
        send(0, 11'h3FF, 56'h80_0000_0000_0001, 0, RM_RUP, {64'h3FF0_0000_0000_0001, 3'b100});
        send(0, 11'h3FF, 56'h80_0000_0000_0001, 0, RM_RTZ, {64'h3FF0_0000_0000_0000, 3'b100});
        send(0, 11'h000, 56'h00_0000_0000_0011, 0, RM_RNE, {64'h0000_0000_0000_0002, 3'b101});
        send(0, 11'h400, 56'h80_0000_0000_0000, 1, RM_RNE, {64'h4000_0000_0000_0000, 3'b000});
        idle();
        drain();

        pat_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic        sg;
            logic [10:0] e;
            logic [51:0] f;
            sg = 1'(i % 2);
            e  = 11'(11'h400 + i);
            f  = 52'((i + 1) * 'h1111);
            send(sg, e, {1'b1, f, 3'b000}, 0, 3'(i % 5), {sg, e, f, 3'b000});
        end
        idle();
        drain();
        pat_en = 1'b0;
        repeat (2) @(negedge clk);

        send(0, 11'h3FF, 56'h80_0000_0000_0004, 0, RM_RNE, {64'h3FF0_0000_0000_0000, 3'b100});
        send(0, 11'h3FF, 56'h80_0000_0000_000C, 0, RM_RNE, {64'h3FF0_0000_0000_0002, 3'b100});
        @(negedge clk);
        rst_n = 1'b0;
        i_valid = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        chk("rst_flush_valid", {67'd0, o_valid}, 68'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
            chk("rst_no_ghost", {67'd0, o_valid}, 68'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
